datamem_arbiter: RTL

- Shares the single-port 16-bit data memory between two requesters:
  - the pipeline's memory stage (ldr/str), and
  - a loader/debug port used for preloading and inspecting datamem.
- Registered grant, fixed-latency read return, pipeline-priority arbitration with a starvation limit for the loader.
- Sits between stage three and the datamem array, replacing its direct access.

---
 rtl/datamem_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/datamem_arbiter.sv
// Shares the single-port data memory between the pipeline memory stage and the
// loader/debug port: registered grant, fixed-latency read return, starvation-limited priority.
module datamem_arbiter #(
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_req,
    input  logic        p_we,
    input  logic [15:0] p_addr,
    input  logic [15:0] p_wdata,
    output logic        p_gnt,
    output logic        p_rvalid,
    output logic [15:0] p_rdata,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [15:0] l_addr,
    input  logic [15:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [15:0] l_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, GRANT, RWAIT, RESP} state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
    localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic        win_l_q, win_l_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  starve_q, starve_d;
    logic [15:0] p_rdata_q, p_rdata_d;
    logic [15:0] l_rdata_q, l_rdata_d;
    logic        pick_l;

    always_comb begin
        state_d   = state_q;
        win_l_d   = win_l_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wait_d    = wait_q;
        starve_d  = starve_q;
        p_rdata_d = p_rdata_q;
        l_rdata_d = l_rdata_q;

        // Pipeline has priority unless the loader has been starved long enough.
        pick_l = l_req && (!p_req || (starve_q >= MAX_WAIT_C));

        case (state_q)
            IDLE, RESP: begin
                if (p_req || l_req) begin
                    state_d = GRANT;
                    win_l_d = pick_l;
                    we_d    = pick_l ? l_we    : p_we;
                    addr_d  = pick_l ? l_addr  : p_addr;
                    wdata_d = pick_l ? l_wdata : p_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                state_d = we_q ? IDLE : RWAIT;
                wait_d  = LAT_LAST;
            end
            RWAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = RESP;
                    if (win_l_q) begin
                        l_rdata_d = m_rdata;
                    end else begin
                        p_rdata_d = m_rdata;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (l_gnt) begin
            starve_d = 8'd0;
        end else if (l_req && (starve_q < MAX_WAIT_C)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    // Reset also discards any in-flight read, so no stale rvalid can follow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            win_l_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 16'd0;
            wdata_q   <= 16'd0;
            wait_q    <= 4'd0;
            starve_q  <= 8'd0;
            p_rdata_q <= 16'd0;
            l_rdata_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            win_l_q   <= win_l_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            starve_q  <= starve_d;
            p_rdata_q <= p_rdata_d;
            l_rdata_q <= l_rdata_d;
        end
    end

    assign p_gnt    = (state_q == GRANT) && !win_l_q;
    assign l_gnt    = (state_q == GRANT) &&  win_l_q;
    assign p_rvalid = (state_q == RESP)  && !win_l_q;
    assign l_rvalid = (state_q == RESP)  &&  win_l_q;
    assign m_en     = (state_q == GRANT);
    assign m_we     = (state_q == GRANT) && we_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign p_rdata  = p_rdata_q;
    assign l_rdata  = l_rdata_q;
    assign busy     = (state_q != IDLE);

endmodule
